fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter RESET_PC SHALL be: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Ports SHALL be as follows; all widths in bits:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirect  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  32  redirect target.
- stall  in  1  hazard stall; suppress new requests.
- mux_a  out  32  to external 2:1 pc mux input a: pc+4.
- mux_b  out  32  to external mux input b: redirect target.
- mux_sel  out  1  to external mux select.
- mux_y  in  32  external mux output; next pc.
- imem_req_valid  out  1  instruction-memory request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  request address.
- imem_rsp_valid  in  1  one-cycle response strobe.
- imem_rsp_data  in  32  instruction word.
- if_valid  out  1  IF/ID output valid.
- if_pc  out  32  pc of delivered instruction.
- if_instr  out  32  delivered instruction.
- if_ready  in  1  decode consumes the instruction.

Function
REQ-003 mux_a SHALL equal pc+4 modulo 2^32 (wrap 32'hFFFF_FFFC -> 0).
REQ-004 mux_b SHALL equal {redirect_pc[31:2],2'b00}; mux_sel SHALL equal redirect.
REQ-005 pc SHALL load only from mux_y, and only on the update events of REQ-008/REQ-010.
REQ-006 FSM states SHALL be: REQ, WAIT, HOLD, DRAIN; at most one memory request outstanding.
REQ-007 REQ: imem_req_valid = ~stall; imem_addr = pc; valid&ready -> WAIT; imem_addr is held stable while valid is high and ready is low.
REQ-008 WAIT: on imem_rsp_valid, capture if_instr = rsp_data and if_pc = pc, set if_valid, load pc (mux_sel=0 -> pc+4), and go to HOLD.
REQ-009 HOLD: if_valid, if_pc and if_instr SHALL be held until if_ready=1; then clear if_valid and go to REQ; stall does not clear if_valid.
REQ-010 Redirect in any state SHALL load pc from mux_y (= aligned target) and clear if_valid in the same edge; redirect has priority over stall and if_ready.
REQ-011 Redirect next state: REQ->REQ when no handshake occurs that cycle; REQ with handshake ->DRAIN; WAIT without rsp ->DRAIN; WAIT with rsp ->REQ, with the response discarded; HOLD->REQ; DRAIN->DRAIN.
REQ-012 DRAIN: imem_req_valid=0; the next imem_rsp_valid SHALL be discarded, and the FSM SHALL then go to REQ with pc unchanged.
REQ-013 imem_rsp_valid in REQ or HOLD SHALL be ignored.
REQ-014 Minimum latency SHALL be: request accepted at edge N, response at edge N+k, if_valid high from edge N+k.

Reset
REQ-015 While rst_n=0, outputs SHALL be: pc=RESET_PC, state=REQ, if_valid=0, if_pc=0, if_instr=0.
REQ-016 Reset assertion mid-operation SHALL abort any outstanding request. No drain is performed; a stale response after reset release is the memory's responsibility.
REQ-017 The first request SHALL present imem_addr=RESET_PC in the first cycle after rst_n rises, provided stall=0.

Structure
REQ-018 Package fetch_pkg SHALL hold the FSM state enum, the PC_INC=4 constant and the 32-bit word width constant.
REQ-019 The IF/ID output register (if_valid/if_pc/if_instr with load/hold/clear) SHALL be a sub-module named if_id_reg; the 2:1 pc mux stays external.

Verification
REQ-020 Reset then idle memory (ready=1, rsp one cycle after accept, if_ready=1) -> if_pc sequence 0,4,8,C with matching instructions.
REQ-021 if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc and if_instr stable; no new request; resumes on release.
REQ-022 Redirect to 32'h0000_0103 while in WAIT -> DRAIN; the stale rsp is dropped; the next request addr is 32'h0000_0100; no if_valid for the dropped word.
REQ-023 Redirect coincident with rsp_valid in WAIT -> no if_valid, and the next imem_addr is the target.
REQ-024 stall=1 in REQ for 3 cycles -> imem_req_valid=0 throughout; redirect during stall still loads the target.
REQ-025 pc=32'hFFFF_FFFC fetched -> next imem_addr=0; rst_n pulled low in WAIT -> outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch PC unit.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if_id_reg.sv
// IF/ID pipeline register: captures a fetched word, holds it until consumed.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  // clear wins over load so a redirect can never let a wrong-path word through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
      instr <= instr_in;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC sequencer: one outstanding imem request, redirect/drain handling,
// next PC chosen by an external 2:1 mux (pc+4 vs aligned redirect target).
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] mux_a,
  output logic [31:0] mux_b,
  output logic        mux_sel,
  input  logic [31:0] mux_y,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc;
  logic            req_hs;
  logic            rsp_take;
  logic            pc_load;
  logic            if_load;
  logic            if_clear;

  assign mux_a   = pc + PC_INC;
  assign mux_b   = word_align(redirect_pc);
  assign mux_sel = redirect;

  assign imem_req_valid = (state == ST_REQ) && !stall;
  assign imem_addr      = pc;

  assign req_hs   = imem_req_valid && imem_req_ready;
  assign rsp_take = (state == ST_WAIT) && imem_rsp_valid;
  assign pc_load  = redirect || rsp_take;
  assign if_load  = rsp_take && !redirect;
  assign if_clear = redirect || ((state == ST_HOLD) && if_ready);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_REQ: begin
        if (redirect)    state_nxt = req_hs ? ST_DRAIN : ST_REQ;
        else if (req_hs) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect)            state_nxt = imem_rsp_valid ? ST_REQ : ST_DRAIN;
        else if (imem_rsp_valid) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (redirect || if_ready) state_nxt = ST_REQ;
      end
      ST_DRAIN: begin
        // A redirect here only retargets pc; the drained response still ends the drain.
        if (imem_rsp_valid) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_REQ;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pc <= RESET_PC;
    else if (pc_load) pc <= mux_y;
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (if_load),
    .clear    (if_clear),
    .pc_in    (pc),
    .instr_in (imem_rsp_data),
    .valid    (if_valid),
    .pc       (if_pc),
    .instr    (if_instr)
  );

  logic unused_lsb;
  assign unused_lsb = ^redirect_pc[1:0];

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req_valid && !imem_req_ready && !redirect) |=> $stable(imem_addr));

  a_single_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    (state != ST_REQ) |-> !imem_req_valid);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with an expected-request / expected-delivery scoreboard.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] mux_a, mux_b, mux_y;
  logic        mux_sel;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic        if_ready;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } dl_t;

  logic [31:0] exp_req_q[$];
  dl_t         exp_dl_q[$];
  int          total = 0;
  int          bad   = 0;
  int          rsp_delay = 1;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .mux_a          (mux_a),
    .mux_b          (mux_b),
    .mux_sel        (mux_sel),
    .mux_y          (mux_y),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready)
  );

  // external 2:1 pc mux
  assign mux_y = mux_sel ? mux_b : mux_a;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input logic [31:0] a);
    exp_req_q.push_back(a);
  endtask

  task automatic push_dl(input logic [31:0] a);
    dl_t d;
    d.pc = a;
    d.instr = f(a);
    exp_dl_q.push_back(d);
  endtask

  // memory model: responds rsp_delay cycles after an accepted request
  initial begin
    logic        hs;
    logic        pending;
    logic [31:0] ha, pa;
    int          cnt;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pending = 1'b0;
    pa = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      hs = rst_n && imem_req_valid && imem_req_ready;
      ha = imem_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
      end else begin
        if (hs) begin
          pending = 1'b1;
          pa = ha;
          cnt = rsp_delay;
        end
        if (pending) begin
          cnt--;
          if (cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = f(pa);
            pending = 1'b0;
          end
        end
      end
    end
  end

  // request monitor
  always @(negedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) begin
      if (exp_req_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL req_unexpected: got addr %h want no request (t=%0t)", imem_addr, $time);
      end else begin
        chk("req_addr", imem_addr, exp_req_q.pop_front());
      end
    end
  end

  // delivery monitor
  always @(negedge clk) begin
    if (rst_n && if_valid && if_ready && !redirect) begin
      if (exp_dl_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dl_unexpected: got pc %h instr %h want no delivery (t=%0t)", if_pc, if_instr, $time);
      end else begin
        dl_t d;
        d = exp_dl_q.pop_front();
        chk("dl_pc", if_pc, d.pc);
        chk("dl_instr", if_instr, d.instr);
      end
    end
  end

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_req_q.size() != 0 || exp_dl_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_req_q.size() != 0 || exp_dl_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d/%0d pending want 0/0", exp_req_q.size(), exp_dl_q.size());
    end
    @(posedge clk);
    #1;
    imem_req_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    stall = 1'b0;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_mux_a", mux_a, 32'd4);

    // sequential fetch 0,4,8,C
    push_req(32'h0); push_req(32'h4); push_req(32'h8); push_req(32'hC);
    push_dl(32'h0);  push_dl(32'h4);  push_dl(32'h8);  push_dl(32'hC);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_drain(60);

    // decode back-pressure in HOLD
    if_ready = 1'b0;
    push_req(32'h10);
    push_dl(32'h10);
    imem_req_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_valid && n < 20);
    for (int unsigned i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      chk("hold_valid", {31'b0, if_valid}, 32'd1);
      chk("hold_pc", if_pc, 32'h10);
      chk("hold_instr", if_instr, f(32'h10));
      chk("hold_noreq", {31'b0, imem_req_valid}, 32'd0);
    end
    @(posedge clk); #1;
    if_ready = 1'b1;
    wait_drain(20);

    // redirect in WAIT -> DRAIN, stale response dropped
    rsp_delay = 3;
    push_req(32'h14);
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    chk("drain_mux_b", mux_b, 32'h100);
    chk("drain_mux_sel", {31'b0, mux_sel}, 32'd1);
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("drain_noreq0", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    chk("drain_noreq1", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    chk("drain_addr", imem_addr, 32'h100);
    chk("drain_req", {31'b0, imem_req_valid}, 32'd1);
    chk("drain_no_if", {31'b0, if_valid}, 32'd0);
    rsp_delay = 1;
    push_req(32'h100);
    push_dl(32'h100);
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    wait_drain(20);

    // redirect coincident with response in WAIT
    push_req(32'h104);
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("coinc_no_if", {31'b0, if_valid}, 32'd0);
    chk("coinc_addr", imem_addr, 32'h200);
    chk("coinc_req", {31'b0, imem_req_valid}, 32'd1);
    push_req(32'h200);
    push_dl(32'h200);
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    wait_drain(20);

    // stall in REQ, redirect during stall
    stall = 1'b1;
    imem_req_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_noreq", {31'b0, imem_req_valid}, 32'd0);
    end
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0300;
    @(negedge clk);
    chk("stall_redir_noreq", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("stall_redir_addr", imem_addr, 32'h300);
    chk("stall_redir_noreq2", {31'b0, imem_req_valid}, 32'd0);
    push_req(32'h300);
    push_dl(32'h300);
    @(posedge clk); #1;
    stall = 1'b0;
    wait_drain(20);

    // pc wrap at top of address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_mux_a", mux_a, 32'h0);
    push_req(32'hFFFF_FFFC); push_req(32'h0);
    push_dl(32'hFFFF_FFFC);  push_dl(32'h0);
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    wait_drain(30);

    // reset asserted while in WAIT
    rsp_delay = 3;
    push_req(32'h4);
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("wrst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("wrst_if_pc", if_pc, 32'd0);
    chk("wrst_if_instr", if_instr, 32'd0);
    chk("wrst_addr", imem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rsp_delay = 1;
    push_req(32'h0);
    push_dl(32'h0);
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    wait_drain(20);

    chk("left_req", exp_req_q.size(), 32'd0);
    chk("left_dl", exp_dl_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
